// File: rtl/pll_cfg_pkg.sv
// Shared types and defaults for the rPLL dynamic-configuration controller.
// Code widths match the rPLL IDSEL/FBDSEL/ODSEL (6 bit) and PSDA/DUTYDA (4 bit) ports.
package pll_cfg_pkg;

   localparam int unsigned DivW = 6;
   localparam int unsigned PsW  = 4;

   localparam logic [DivW-1:0] DefIdsel  = 6'd0;
   localparam logic [DivW-1:0] DefFbdsel = 6'd0;
   localparam logic [DivW-1:0] DefOdsel  = 6'd0;
   localparam logic [PsW-1:0]  DefPsda   = 4'd0;
   localparam logic [PsW-1:0]  DefDutyda = 4'd8;

   typedef enum logic [2:0] {
      StRstHold,
      StWaitLock,
      StReady,
      StPsSettle,
      StFail
   } pll_state_e;

   typedef struct packed {
      logic [DivW-1:0] idsel;
      logic [DivW-1:0] fbdsel;
      logic [DivW-1:0] odsel;
      logic [PsW-1:0]  psda;
      logic [PsW-1:0]  dutyda;
   } pll_codes_t;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous control bit.
module sync_2ff #(
   parameter logic ResetVal = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= ResetVal;
         sync_q <= ResetVal;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_dyn_cfg_ctrl.sv
// Boot, reconfiguration and lock supervision for the rPLL dynamic ports.
// Runs on the free-running board clock; the PLL output clock is never used here.
module pll_dyn_cfg_ctrl
   import pll_cfg_pkg::*;
#(
   parameter int unsigned     RST_HOLD_CYC     = 16,
   parameter int unsigned     LOCK_TIMEOUT_CYC = 65536,
   parameter int unsigned     LOCK_STABLE_CYC  = 256,
   parameter int unsigned     PS_SETTLE_CYC    = 64,
   parameter int unsigned     MAX_RETRY        = 3,
   parameter logic [DivW-1:0] DEF_IDSEL        = DefIdsel,
   parameter logic [DivW-1:0] DEF_FBDSEL       = DefFbdsel,
   parameter logic [DivW-1:0] DEF_ODSEL        = DefOdsel,
   parameter logic [PsW-1:0]  DEF_PSDA         = DefPsda,
   parameter logic [PsW-1:0]  DEF_DUTYDA       = DefDutyda
) (
   input  logic            sys_clk,
   input  logic            sys_rst_n,
   input  logic            cfg_req,
   input  logic [DivW-1:0] cfg_idsel,
   input  logic [DivW-1:0] cfg_fbdsel,
   input  logic [DivW-1:0] cfg_odsel,
   input  logic [PsW-1:0]  cfg_psda,
   input  logic [PsW-1:0]  cfg_dutyda,
   output logic            cfg_busy,
   output logic            cfg_done,
   output logic            cfg_err,
   output logic [1:0]      retry_cnt,
   input  logic            pll_lock,
   output logic            pll_reset,
   output logic [DivW-1:0] pll_idsel,
   output logic [DivW-1:0] pll_fbdsel,
   output logic [DivW-1:0] pll_odsel,
   output logic [PsW-1:0]  pll_psda,
   output logic [PsW-1:0]  pll_dutyda,
   output logic            pll_ready,
   output logic            user_rst_n
);

   localparam int unsigned PhaseMax = (RST_HOLD_CYC > PS_SETTLE_CYC) ? RST_HOLD_CYC : PS_SETTLE_CYC;
   localparam int unsigned PhW      = cnt_width(PhaseMax);
   localparam int unsigned TmoW     = cnt_width(LOCK_TIMEOUT_CYC);
   localparam int unsigned StbW     = cnt_width(LOCK_STABLE_CYC);

   localparam logic [PhW-1:0]  HoldLast   = PhW'(RST_HOLD_CYC - 1);
   localparam logic [PhW-1:0]  SettleLast = PhW'(PS_SETTLE_CYC - 1);
   localparam logic [TmoW-1:0] TmoLast    = TmoW'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [StbW-1:0] StbLast    = StbW'(LOCK_STABLE_CYC - 1);
   localparam logic [1:0]      RetryMax   = 2'(MAX_RETRY);

   localparam pll_codes_t DefCodes = {DEF_IDSEL, DEF_FBDSEL, DEF_ODSEL, DEF_PSDA, DEF_DUTYDA};

   pll_state_e      state_q, state_d;
   logic [PhW-1:0]  phase_q, phase_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic [StbW-1:0] stb_q, stb_d;
   logic [1:0]      retry_q, retry_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            ready_q, ready_d;
   logic            pll_reset_q, pll_reset_d;
   logic            user_rst_n_q;
   pll_codes_t      codes_q, codes_d;

   pll_codes_t      req_codes;
   logic            lock_s;
   logic            accept;
   logic            div_same;

   sync_2ff #(
      .ResetVal (1'b0)
   ) u_lock_sync (
      .clk_i  (sys_clk),
      .rst_ni (sys_rst_n),
      .d_i    (pll_lock),
      .q_o    (lock_s)
   );

   assign req_codes = {cfg_idsel, cfg_fbdsel, cfg_odsel, cfg_psda, cfg_dutyda};
   assign accept    = cfg_req & ~busy_q;
   assign div_same  = (req_codes.idsel == codes_q.idsel) && (req_codes.fbdsel == codes_q.fbdsel)
                      && (req_codes.odsel == codes_q.odsel);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      tmo_d   = tmo_q;
      stb_d   = stb_q;
      retry_d = retry_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      ready_d = ready_q;
      codes_d = codes_q;
      unique case (state_q)
         StRstHold: begin
            if (phase_q >= HoldLast) begin
               state_d = StWaitLock;
               phase_d = '0;
               tmo_d   = '0;
               stb_d   = '0;
            end else begin
               phase_d = phase_q + PhW'(1);
            end
         end
         StWaitLock: begin
            tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TmoW'(1);
            stb_d = !lock_s ? '0 : ((stb_q == '1) ? stb_q : stb_q + StbW'(1));
            // Lock is checked first so it wins a tie with the timeout.
            if (lock_s && (stb_q >= StbLast)) begin
               state_d = StReady;
               ready_d = 1'b1;
               done_d  = 1'b1;
            end else if (tmo_q >= TmoLast) begin
               if (retry_q < RetryMax) begin
                  retry_d = retry_q + 2'd1;
                  state_d = StRstHold;
                  phase_d = '0;
               end else begin
                  state_d = StFail;
                  err_d   = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end
         StReady, StPsSettle: begin
            if (!lock_s) begin
               // Lock loss: requalify without resetting the PLL; a concurrent request is dropped.
               state_d = StWaitLock;
               ready_d = 1'b0;
               busy_d  = 1'b1;
               retry_d = '0;
               tmo_d   = '0;
               stb_d   = '0;
            end else if (state_q == StPsSettle) begin
               if (phase_q >= SettleLast) begin
                  state_d = StReady;
                  done_d  = 1'b1;
               end else begin
                  phase_d = phase_q + PhW'(1);
               end
            end else if (accept) begin
               codes_d = req_codes;
               busy_d  = 1'b1;
               retry_d = '0;
               err_d   = 1'b0;
               phase_d = '0;
               if (div_same) begin
                  state_d = StPsSettle;
               end else begin
                  state_d = StRstHold;
                  ready_d = 1'b0;
               end
            end else begin
               busy_d = 1'b0;
            end
         end
         StFail: begin
            if (accept) begin
               codes_d = req_codes;
               busy_d  = 1'b1;
               retry_d = '0;
               err_d   = 1'b0;
               phase_d = '0;
               state_d = StRstHold;
            end
         end
         default: state_d = StRstHold;
      endcase
   end

   assign pll_reset_d = (state_d == StRstHold) || (state_d == StFail);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= StRstHold;
         phase_q      <= '0;
         tmo_q        <= '0;
         stb_q        <= '0;
         retry_q      <= '0;
         busy_q       <= 1'b1;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         ready_q      <= 1'b0;
         pll_reset_q  <= 1'b1;
         user_rst_n_q <= 1'b0;
         codes_q      <= DefCodes;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         tmo_q        <= tmo_d;
         stb_q        <= stb_d;
         retry_q      <= retry_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         ready_q      <= ready_d;
         pll_reset_q  <= pll_reset_d;
         user_rst_n_q <= pll_ready;
         codes_q      <= codes_d;
      end
   end

   // Gating with lock_s drops pll_ready the cycle the synchronized lock falls.
   assign pll_ready  = ready_q & lock_s;
   assign user_rst_n = user_rst_n_q;
   assign pll_reset  = pll_reset_q;
   assign cfg_busy   = busy_q;
   assign cfg_done   = done_q;
   assign cfg_err    = err_q;
   assign retry_cnt  = retry_q;
   assign pll_idsel  = codes_q.idsel;
   assign pll_fbdsel = codes_q.fbdsel;
   assign pll_odsel  = codes_q.odsel;
   assign pll_psda   = codes_q.psda;
   assign pll_dutyda = codes_q.dutyda;

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Bench for pll_dyn_cfg_ctrl: a timestamp-based reference model compared every cycle,
// plus directed scenarios with hand-computed timing expectations.
module tb_pll_dyn_cfg_ctrl;

   localparam int HOLD  = 4;
   localparam int STB   = 8;
   localparam int TMO   = 100;
   localparam int SET   = 5;
   localparam int RETRY = 3;

   localparam int M_HOLD   = 0;
   localparam int M_WAIT   = 1;
   localparam int M_READY  = 2;
   localparam int M_SETTLE = 3;
   localparam int M_FAIL   = 4;

   localparam logic [25:0] DEF_CODES = {6'd0, 6'd0, 6'd0, 4'd0, 4'd8};

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       cfg_req   = 1'b0;
   logic [5:0] cfg_idsel = '0, cfg_fbdsel = '0, cfg_odsel = '0;
   logic [3:0] cfg_psda  = '0, cfg_dutyda = 4'd8;
   logic       pll_lock  = 1'b0;
   logic       cfg_busy, cfg_done, cfg_err, pll_reset, pll_ready, user_rst_n;
   logic [1:0] retry_cnt;
   logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
   logic [3:0] pll_psda, pll_dutyda;

   int n_pass  = 0;
   int n_total = 0;

   always #5 sys_clk = ~sys_clk;

   pll_dyn_cfg_ctrl #(
      .RST_HOLD_CYC     (HOLD),
      .LOCK_TIMEOUT_CYC (TMO),
      .LOCK_STABLE_CYC  (STB),
      .PS_SETTLE_CYC    (SET),
      .MAX_RETRY        (RETRY)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .cfg_req    (cfg_req),
      .cfg_idsel  (cfg_idsel),
      .cfg_fbdsel (cfg_fbdsel),
      .cfg_odsel  (cfg_odsel),
      .cfg_psda   (cfg_psda),
      .cfg_dutyda (cfg_dutyda),
      .cfg_busy   (cfg_busy),
      .cfg_done   (cfg_done),
      .cfg_err    (cfg_err),
      .retry_cnt  (retry_cnt),
      .pll_lock   (pll_lock),
      .pll_reset  (pll_reset),
      .pll_idsel  (pll_idsel),
      .pll_fbdsel (pll_fbdsel),
      .pll_odsel  (pll_odsel),
      .pll_psda   (pll_psda),
      .pll_dutyda (pll_dutyda),
      .pll_ready  (pll_ready),
      .user_rst_n (user_rst_n)
   );

   // Reference model: phases with absolute deadlines (edge numbers) instead of counters.
   int          m_n, m_mode, m_leave_at, m_tmo_at, m_settle_at, m_run, m_retry;
   bit          m_rst, m_ready, m_urst, m_busy, m_done, m_err, m_ls;
   logic [25:0] m_codes;
   bit          m_hist[$];

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         m_n = 0; m_mode = M_HOLD; m_leave_at = HOLD; m_tmo_at = 0; m_settle_at = 0;
         m_run = 0; m_retry = 0; m_rst = 1; m_ready = 0; m_urst = 0; m_busy = 1;
         m_done = 0; m_err = 0; m_ls = 0; m_codes = DEF_CODES;
         m_hist.delete(); m_hist.push_back(1'b0); m_hist.push_back(1'b0);
      end else begin : model_step
         bit ls_pre, acc;
         ls_pre = m_hist[0];
         m_urst = m_ready && ls_pre;
         void'(m_hist.pop_front());
         m_hist.push_back(pll_lock);
         m_n++;
         m_done = 0;
         acc = cfg_req && !m_busy;
         case (m_mode)
            M_HOLD: if (m_n == m_leave_at) begin
               m_mode = M_WAIT; m_tmo_at = m_n + TMO; m_run = 0; m_rst = 0;
            end
            M_WAIT: begin
               m_run = ls_pre ? m_run + 1 : 0;
               if (m_run == STB) begin
                  m_mode = M_READY; m_ready = 1; m_done = 1;
               end else if (m_n == m_tmo_at) begin
                  if (m_retry < RETRY) begin
                     m_retry++; m_mode = M_HOLD; m_leave_at = m_n + HOLD; m_rst = 1;
                  end else begin
                     m_mode = M_FAIL; m_err = 1; m_busy = 0; m_rst = 1;
                  end
               end
            end
            M_READY, M_SETTLE: begin
               if (!ls_pre) begin
                  m_mode = M_WAIT; m_ready = 0; m_busy = 1; m_retry = 0;
                  m_tmo_at = m_n + TMO; m_run = 0;
               end else if (m_mode == M_SETTLE) begin
                  if (m_n == m_settle_at) begin
                     m_mode = M_READY; m_done = 1;
                  end
               end else if (acc) begin
                  m_busy = 1; m_retry = 0; m_err = 0;
                  if ({cfg_idsel, cfg_fbdsel, cfg_odsel} == m_codes[25:8]) begin
                     m_mode = M_SETTLE; m_settle_at = m_n + SET;
                  end else begin
                     m_mode = M_HOLD; m_leave_at = m_n + HOLD; m_rst = 1; m_ready = 0;
                  end
                  m_codes = {cfg_idsel, cfg_fbdsel, cfg_odsel, cfg_psda, cfg_dutyda};
               end else begin
                  m_busy = 0;
               end
            end
            default: if (acc) begin
               m_codes = {cfg_idsel, cfg_fbdsel, cfg_odsel, cfg_psda, cfg_dutyda};
               m_busy = 1; m_retry = 0; m_err = 0;
               m_mode = M_HOLD; m_leave_at = m_n + HOLD; m_rst = 1;
            end
         endcase
         m_ls = m_hist[0];
      end
   end

   int done_cnt  = 0;
   int rst_falls = 0;
   logic rst_prev = 1'b1;

   always @(negedge sys_clk) begin
      if (cfg_done) done_cnt <= done_cnt + 1;
      if (rst_prev && !pll_reset) rst_falls <= rst_falls + 1;
      rst_prev <= pll_reset;
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic request(input logic [5:0] id, fb, od, input logic [3:0] ps, du);
      cfg_idsel = id; cfg_fbdsel = fb; cfg_odsel = od; cfg_psda = ps; cfg_dutyda = du;
      cfg_req = 1'b1;
      tick(1);
      cfg_req = 1'b0;
   endtask

   task automatic wait_ready(input int budget, output int k);
      k = 0;
      do begin tick(1); k++; end while (!pll_ready && k < budget);
   endtask

   task automatic wait_rst_fall(input int budget, output int k);
      k = 0;
      do begin tick(1); k++; end while (pll_reset && k < budget);
   endtask

   initial begin
      int k, d0, f0;
      logic [33:0] act, exp;
      fork
         forever begin
            @(negedge sys_clk);
            act = {pll_reset, pll_ready, user_rst_n, cfg_busy, cfg_done, cfg_err, retry_cnt,
                   pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda};
            exp = {m_rst, m_ready & m_ls, m_urst, m_busy, m_done, m_err, 2'(m_retry), m_codes};
            n_total++;
            if (act === exp) n_pass++;
            else $display("FAIL cycle-compare t=%0t actual=%h required=%h", $time, act, exp);
         end
      join_none

      repeat (3) @(posedge sys_clk);
      check("reset pll_reset", int'(pll_reset), 1);
      check("reset dutyda", int'(pll_dutyda), 8);
      check("reset busy", int'(cfg_busy), 1);
      check("reset user_rst_n", int'(user_rst_n), 0);
      @(negedge sys_clk) sys_rst_n = 1'b1;

      // Boot
      wait_rst_fall(50, k);
      check("boot pll_reset high cycles", k, 4);
      tick(10);
      pll_lock = 1'b1;
      d0 = done_cnt;
      wait_ready(200, k);
      check("boot lock-to-ready cycles", k, 10);
      check("boot done with ready", int'(cfg_done), 1);
      check("boot user_rst_n lags ready", int'(user_rst_n), 0);
      tick(1);
      check("boot user_rst_n", int'(user_rst_n), 1);
      check("boot busy dropped", int'(cfg_busy), 0);
      check("boot done count", done_cnt - d0, 1);

      // Divider change
      tick(2);
      request(6'h00, 6'h00, 6'h3C, 4'h0, 4'h8);
      pll_lock = 1'b0;
      check("div odsel latched", int'(pll_odsel), 'h3C);
      check("div pll_reset on accept", int'(pll_reset), 1);
      check("div ready dropped", int'(pll_ready), 0);
      d0 = done_cnt;
      wait_rst_fall(50, k);
      check("div hold cycles", k, 4);
      tick(3);
      pll_lock = 1'b1;
      wait_ready(200, k);
      check("div relock cycles", k, 10);
      tick(1);
      check("div done count", done_cnt - d0, 1);

      // Phase-only change
      tick(2);
      f0 = rst_falls;
      request(6'h00, 6'h00, 6'h3C, 4'h5, 4'h8);
      check("ps psda latched", int'(pll_psda), 5);
      check("ps ready held", int'(pll_ready), 1);
      k = 0;
      do begin tick(1); k++; end while (!cfg_done && k < 20);
      check("ps done latency", k, 5);
      check("ps no pll reset", int'(pll_reset) + rst_falls - f0, 0);

      // Lock glitch during WAIT_LOCK at stable count 6
      tick(2);
      request(6'h00, 6'h00, 6'h10, 4'h5, 4'h8);
      pll_lock = 1'b0;
      wait_rst_fall(50, k);
      pll_lock = 1'b1;
      tick(6);
      pll_lock = 1'b0;
      tick(3);
      check("glitch not ready early", int'(pll_ready), 0);
      pll_lock = 1'b1;
      wait_ready(200, k);
      check("glitch ready after restored lock", k, 10);

      // Lock never asserts
      tick(2);
      f0 = rst_falls;
      request(6'h00, 6'h00, 6'h3C, 4'h5, 4'h8);
      pll_lock = 1'b0;
      k = 0;
      do begin tick(1); k++; end while (!cfg_err && k < 1000);
      check("fail cycles to err", k, 4 * (HOLD + TMO));
      check("fail retry_cnt", int'(retry_cnt), 3);
      check("fail pll_reset", int'(pll_reset), 1);
      check("fail busy", int'(cfg_busy), 0);
      check("fail attempts", rst_falls - f0, 4);
      tick(2);
      request(6'h00, 6'h00, 6'h3C, 4'h5, 4'h8);
      check("fail req clears err", int'(cfg_err), 0);
      check("fail req busy", int'(cfg_busy), 1);
      check("fail req retry", int'(retry_cnt), 0);
      wait_rst_fall(50, k);
      check("fail full reset path", k, 4);
      pll_lock = 1'b1;
      wait_ready(200, k);
      check("fail recovery cycles", k, 10);

      // Runtime lock loss with a concurrent request
      tick(2);
      d0 = done_cnt;
      f0 = rst_falls;
      pll_lock = 1'b0;
      tick(2);
      check("loss ready fell", int'(pll_ready), 0);
      cfg_psda = 4'hA; cfg_odsel = 6'h2A; cfg_req = 1'b1;
      tick(1);
      cfg_req = 1'b0;
      check("loss user_rst_n fell", int'(user_rst_n), 0);
      check("loss busy", int'(cfg_busy), 1);
      check("loss request dropped", int'(pll_odsel), 'h3C);
      pll_lock = 1'b1;
      wait_ready(200, k);
      check("loss recovery cycles", k, 10);
      tick(1);
      check("loss done count", done_cnt - d0, 1);
      check("loss no pll reset", rst_falls - f0, 0);
      check("loss psda kept", int'(pll_psda), 5);

      // Reset mid-sequence restores defaults
      tick(2);
      request(6'h11, 6'h00, 6'h3C, 4'h5, 4'h8);
      pll_lock = 1'b0;
      tick(2);
      sys_rst_n = 1'b0;
      #1;
      check("rst idsel restored", int'(pll_idsel), 0);
      check("rst psda restored", int'(pll_psda), 0);
      tick(2);
      @(negedge sys_clk) sys_rst_n = 1'b1;
      wait_rst_fall(50, k);
      check("rst reboot hold", k, 4);
      pll_lock = 1'b1;
      wait_ready(200, k);
      check("rst reboot ready", k, 10);
      tick(3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
